rgb_axis_packer: RTL and testbench

//  Packs the 24-bit RGB888 pixels produced by the pixel generator into a 32-bit AXI4-Stream video stream (4 pixels -> 3 words).

---
 rtl/rgb_axis_pkg.sv | 18 +
 rtl/axis_word_fifo.sv | 49 ++++
 rtl/rgb_axis_packer.sv | 177 +++++++++++++++++
 tb/tb_rgb_axis_packer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_axis_pkg.sv
// rtl/rgb_axis_pkg.sv - shared types and constants for the RGB888 to 32-bit stream packer
package rgb_axis_pkg;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  localparam logic [3:0] KEEP_FULL = 4'hF;
  localparam logic [3:0] KEEP_3B   = 4'h7;
  localparam logic [3:0] KEEP_2B   = 4'h3;
  localparam logic [3:0] KEEP_1B   = 4'h1;

  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
  } word_t;

endpackage

// File: rtl/axis_word_fifo.sv
// rtl/axis_word_fifo.sv - small register FIFO of output words, accepts up to two pushes per cycle
import rgb_axis_pkg::*;

module axis_word_fifo #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_a,
  input  word_t         data_a,
  input  logic          push_b,
  input  word_t         data_b,
  input  logic          pop,
  output word_t         head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  word_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  n_push;

  // push_b is only ever raised together with push_a and lands in the following slot
  assign n_push = CW'(push_a) + CW'(push_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_a) mem[wr_ptr] <= data_a;
      if (push_b) mem[wr_ptr + AW'(1)] <= data_b;
      wr_ptr <= wr_ptr + AW'(n_push);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + n_push - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/rgb_axis_packer.sv
// rtl/rgb_axis_packer.sv - packs RGB888 pixels four-into-three 32-bit stream words with sof/eol framing
import rgb_axis_pkg::*;

module rgb_axis_packer #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [7:0]       r,
  input  logic [7:0]       g,
  input  logic [7:0]       b,
  input  logic             valid,
  input  logic             sof,
  input  logic             eol,
  output logic             in_stream_ready,
  output logic [31:0]      out_stream_tdata,
  output logic [3:0]       out_stream_tkeep,
  output logic             out_stream_tlast,
  output logic             out_stream_tuser,
  output logic             out_stream_tvalid,
  input  logic             out_stream_tready,
  output logic [CNT_W-1:0] err_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  phase_t        phase, phase_nxt, eff;
  logic [23:0]   residue, residue_nxt, res_eff;
  logic          sof_pend, sof_pend_nxt, pend_eff;
  logic          rdy_q;
  logic [23:0]   pixel;
  logic          accept;
  logic          push_a, push_b, pop;
  word_t         word_a, word_b, head;
  logic          empty, full;
  logic [CW-1:0] count;
  logic          err_sof, err_eol;
  logic [CNT_W:0] err_sum;

  assign pixel = {r, g, b};

  // A pixel arriving in PH1/PH2 may be a misaligned eol that needs two slots
  assign in_stream_ready = rdy_q &&
                           (((phase == PH1) || (phase == PH2)) ? (int'(count) + 2 <= FIFO_DEPTH)
                                                               : !full);
  assign accept = valid && in_stream_ready;
  assign pop    = !empty && out_stream_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase     <= PH0;
      residue   <= '0;
      sof_pend  <= 1'b0;
      rdy_q     <= 1'b0;
      err_count <= '0;
    end else begin
      phase     <= phase_nxt;
      residue   <= residue_nxt;
      sof_pend  <= sof_pend_nxt;
      rdy_q     <= 1'b1;
      err_count <= err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    phase_nxt    = phase;
    residue_nxt  = residue;
    sof_pend_nxt = sof_pend;
    push_a       = 1'b0;
    push_b       = 1'b0;
    word_a       = '0;
    word_b       = '0;
    err_sof      = 1'b0;
    err_eol      = 1'b0;
    eff          = phase;
    res_eff      = residue;
    pend_eff     = sof_pend;
    if (accept) begin
      // sof wins first: any partial word of the old frame is abandoned
      if (sof) begin
        err_sof  = (phase != PH0);
        eff      = PH0;
        res_eff  = '0;
        pend_eff = 1'b1;
      end
      err_eol = eol && (eff != PH3);
      case (eff)
        PH0: begin
          if (eol) begin
            push_a       = 1'b1;
            word_a.tdata = {8'h00, pixel};
            word_a.tkeep = KEEP_3B;
            word_a.tlast = 1'b1;
            word_a.tuser = pend_eff;
            sof_pend_nxt = 1'b0;
            residue_nxt  = '0;
            phase_nxt    = PH0;
          end else begin
            sof_pend_nxt = pend_eff;
            residue_nxt  = pixel;
            phase_nxt    = PH1;
          end
        end
        PH1: begin
          push_a       = 1'b1;
          word_a.tdata = {pixel[7:0], res_eff};
          word_a.tkeep = KEEP_FULL;
          word_a.tuser = pend_eff;
          sof_pend_nxt = 1'b0;
          if (eol) begin
            push_b       = 1'b1;
            word_b.tdata = {16'h0000, pixel[23:8]};
            word_b.tkeep = KEEP_2B;
            word_b.tlast = 1'b1;
            residue_nxt  = '0;
            phase_nxt    = PH0;
          end else begin
            residue_nxt  = {8'h00, pixel[23:8]};
            phase_nxt    = PH2;
          end
        end
        PH2: begin
          push_a       = 1'b1;
          word_a.tdata = {pixel[15:0], res_eff[15:0]};
          word_a.tkeep = KEEP_FULL;
          word_a.tuser = pend_eff;
          sof_pend_nxt = 1'b0;
          if (eol) begin
            push_b       = 1'b1;
            word_b.tdata = {24'h000000, pixel[23:16]};
            word_b.tkeep = KEEP_1B;
            word_b.tlast = 1'b1;
            residue_nxt  = '0;
            phase_nxt    = PH0;
          end else begin
            residue_nxt  = {16'h0000, pixel[23:16]};
            phase_nxt    = PH3;
          end
        end
        PH3: begin
          push_a       = 1'b1;
          word_a.tdata = {pixel, res_eff[7:0]};
          word_a.tkeep = KEEP_FULL;
          word_a.tlast = eol;
          word_a.tuser = pend_eff;
          sof_pend_nxt = 1'b0;
          residue_nxt  = '0;
          phase_nxt    = PH0;
        end
      endcase
    end
  end

  assign err_sum = {1'b0, err_count} + {{(CNT_W-1){1'b0}}, ({1'b0, err_sof} + {1'b0, err_eol})};

  axis_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (aclk),
    .rst_n  (aresetn),
    .push_a (push_a),
    .data_a (word_a),
    .push_b (push_b),
    .data_b (word_b),
    .pop    (pop),
    .head   (head),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

  assign out_stream_tdata  = head.tdata;
  assign out_stream_tkeep  = head.tkeep;
  assign out_stream_tlast  = head.tlast;
  assign out_stream_tuser  = head.tuser;
  assign out_stream_tvalid = !empty;

endmodule

// File: tb/tb_rgb_axis_packer.sv
// tb/tb_rgb_axis_packer.sv - randomized self-checking bench for rgb_axis_packer with a byte-stream model
module tb_rgb_axis_packer;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 16;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [7:0]       r = '0, g = '0, b = '0;
  logic             valid = 1'b0, sof = 1'b0, eol = 1'b0;
  logic             in_stream_ready;
  logic [31:0]      out_stream_tdata;
  logic [3:0]       out_stream_tkeep;
  logic             out_stream_tlast;
  logic             out_stream_tuser;
  logic             out_stream_tvalid;
  logic             out_stream_tready = 1'b1;
  logic [CNT_W-1:0] err_count;

  always #5 aclk = ~aclk;

  rgb_axis_packer #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .err_count         (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a byte stream cut into 4-byte words, word = {tdata, tkeep, tlast, tuser}
  logic [7:0]  byte_q[$];
  logic [37:0] exp_q[$];
  logic [37:0] obs_q[$];
  bit          frame_start = 0;
  int          model_err = 0;
  int          n_words = 0;
  int          n_last = 0;
  bit          rand_tready = 0;

  task automatic emit(input int n, input bit last);
    logic [31:0] d;
    logic [3:0]  k;
    d = '0;
    k = '0;
    for (int i = 0; i < n; i++) begin
      d[8*i +: 8] = byte_q.pop_front();
      k[i] = 1'b1;
    end
    exp_q.push_back({d, k, last, frame_start});
    frame_start = 0;
  endtask

  task automatic model_pixel(input logic [23:0] p, input bit s, input bit e);
    if (s) begin
      if (byte_q.size() != 0) model_err++;
      byte_q.delete();
      frame_start = 1;
    end
    for (int i = 0; i < 3; i++) byte_q.push_back(p[8*i +: 8]);
    while (byte_q.size() >= 4) emit(4, e && (byte_q.size() == 4));
    if (e && byte_q.size() != 0) begin
      model_err++;
      emit(byte_q.size(), 1'b1);
    end
  endtask

  initial forever begin
    @(negedge aclk);
    #4;
    if (aresetn) begin
      if (out_stream_tvalid && out_stream_tready) begin
        logic [37:0] obs;
        obs = {out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser};
        obs_q.push_back(obs);
        n_words++;
        if (out_stream_tlast) n_last++;
        check("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("word", 64'(obs), 64'(exp_q.pop_front()));
      end
      if (valid && in_stream_ready) model_pixel({r, g, b}, sof, eol);
    end else begin
      exp_q.delete();
      byte_q.delete();
      frame_start = 0;
      model_err = 0;
    end
  end

  initial forever begin
    @(negedge aclk);
    if (rand_tready) out_stream_tready = 1'($urandom_range(0, 1));
  end

  // Called at a negedge; returns at the negedge after the pixel is taken
  task automatic send(input logic [23:0] p, input bit s, input bit e);
    int n;
    n = 0;
    {r, g, b} = p;
    sof = s;
    eol = e;
    valid = 1'b1;
    #4;
    while (!in_stream_ready && n < 200) begin
      @(negedge aclk);
      #4;
      n++;
    end
    if (n >= 200) check("ready_timeout", 64'(in_stream_ready), 64'd1);
    @(negedge aclk);
    valid = 1'b0;
    sof = 1'b0;
    eol = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    n_words = 0;
    n_last = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] px;
    int len;

    // Reset with valid held high
    valid = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_tvalid", 64'(out_stream_tvalid), 64'd0);
    check("rst_ready", 64'(in_stream_ready), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_word", 64'({out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    valid = 1'b0;
    #1;
    check("ready_before_edge", 64'(in_stream_ready), 64'd0);
    @(posedge aclk);
    #1;
    check("ready_after_edge", 64'(in_stream_ready), 64'd1);
    @(negedge aclk);

    // Four directed pixels
    clear_obs();
    send(24'h112233, 1, 0);
    send(24'h445566, 0, 0);
    send(24'h778899, 0, 0);
    send(24'hAABBCC, 0, 0);
    drain();
    check("t2_count", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() >= 3) begin
      check("t2_w0", 64'(obs_q[0]), 64'({32'h66112233, 4'hF, 1'b0, 1'b1}));
      check("t2_w1", 64'(obs_q[1]), 64'({32'h88994455, 4'hF, 1'b0, 1'b0}));
      check("t2_w2", 64'(obs_q[2]), 64'({32'hAABBCC77, 4'hF, 1'b0, 1'b0}));
    end

    // Full 640-pixel line with random back-pressure
    clear_obs();
    rand_tready = 1;
    for (int x = 0; x < 640; x++) begin
      send(24'($urandom), x == 0, x == 639);
      if ($urandom_range(0, 15) == 0) @(negedge aclk);
    end
    drain();
    rand_tready = 0;
    @(negedge aclk);
    out_stream_tready = 1'b1;
    check("t3_words", 64'(n_words), 64'd480);
    check("t3_tlast_count", 64'(n_last), 64'd1);
    if (obs_q.size() != 0) check("t3_last_flag", 64'(obs_q[obs_q.size()-1][1]), 64'd1);
    check("t3_err", 64'(err_count), 64'd0);

    // Ten-cycle stall mid-line
    clear_obs();
    fork
      begin
        for (int x = 0; x < 16; x++) send(24'($urandom), x == 0, x == 15);
      end
      begin
        logic [37:0] held;
        bit held_v;
        held_v = 0;
        held = '0;
        repeat (3) @(negedge aclk);
        out_stream_tready = 1'b0;
        repeat (10) begin
          @(negedge aclk);
          #4;
          if (held_v) begin
            check("stall_hold", 64'({out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser}), 64'(held));
            check("stall_tvalid", 64'(out_stream_tvalid), 64'd1);
          end else if (out_stream_tvalid) begin
            held_v = 1;
            held = {out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser};
          end
        end
        check("stall_ready_low", 64'(in_stream_ready), 64'd0);
        @(negedge aclk);
        out_stream_tready = 1'b1;
      end
    join
    drain();
    check("t4_words", 64'(n_words), 64'd12);

    // eol at PH1
    clear_obs();
    send(24'h102030, 1, 0);
    send(24'hA1B2C3, 0, 1);
    drain();
    check("t5_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() >= 2) begin
      check("t5_full", 64'(obs_q[0]), 64'({32'hC3102030, 4'hF, 1'b0, 1'b1}));
      check("t5_flush", 64'(obs_q[1]), 64'({32'h0000A1B2, 4'h3, 1'b1, 1'b0}));
    end
    check("t5_err", 64'(err_count), 64'd1);
    clear_obs();
    for (int x = 0; x < 4; x++) send(24'($urandom), 0, x == 3);
    drain();
    check("t5_realign_words", 64'(n_words), 64'd3);
    check("t5_realign_err", 64'(err_count), 64'd1);

    // sof at PH2
    clear_obs();
    send(24'h445566, 1, 0);
    send(24'h778899, 0, 0);
    send(24'h010203, 1, 0);
    send(24'h040506, 0, 0);
    send(24'h070809, 0, 0);
    send(24'h0A0B0C, 0, 1);
    drain();
    check("t6_count", 64'(obs_q.size()), 64'd4);
    if (obs_q.size() >= 2)
      check("t6_new_frame", 64'(obs_q[1]), 64'({32'h06010203, 4'hF, 1'b0, 1'b1}));
    check("t6_err", 64'(err_count), 64'd2);

    // Random frames with stray sof/eol and one mid-line reset
    rand_tready = 1;
    for (int f = 0; f < 8; f++) begin
      len = 4 * $urandom_range(1, 12);
      for (int x = 0; x < len; x++) begin
        if (f == 5 && x == len / 2) begin
          aresetn = 1'b0;
          repeat (2) @(negedge aclk);
          aresetn = 1'b1;
          @(negedge aclk);
        end
        px = 24'($urandom);
        send(px, (x == 0) || ($urandom_range(0, 40) == 0), (x == len - 1) || ($urandom_range(0, 30) == 0));
        if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 3)) @(negedge aclk);
      end
    end
    drain();
    check("rand_err", 64'(err_count), 64'(model_err));
    rand_tready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
